// File: rtl/alu_io_pkg.sv
// Shared types and constants for the ALU result UART transmitter.
package alu_io_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BIT  = 2'd2,
    STOP_BIT  = 2'd3
  } tx_state_e;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int         FRAME_BYTES    = 6;
  localparam logic [2:0] LAST_BYTE_IDX  = 3'(FRAME_BYTES - 1);

  // Byte idx of a frame: 0 is the header, 1..5 come from the 40-bit shadow, MSB first.
  function automatic logic [7:0] frame_byte(input logic [39:0] shadow,
                                            input logic [2:0]  idx,
                                            input logic [7:0]  header);
    logic [7:0] b;
    case (idx)
      3'd1:    b = shadow[39:32];
      3'd2:    b = shadow[31:24];
      3'd3:    b = shadow[23:16];
      3'd4:    b = shadow[15:8];
      3'd5:    b = shadow[7:0];
      default: b = header;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/alu_result_uart_tx_if.sv
// Request/status bundle between the ALU result registers and the UART transmitter.
interface alu_result_uart_tx_if;
  logic        start;
  logic [31:0] data;
  logic [3:0]  flags;
  logic        busy;
  logic        done;
  logic        txd;

  modport master (output start, output data, output flags,
                  input  busy,  input  done, input  txd);

  modport slave  (input  start, input  data, input  flags,
                  output busy,  output done, output txd);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. Owns the baud counter, bit shifting and the txd flop.
// tx_ready is also high in the last cycle of a stop bit, so a byte offered
// then starts immediately with no idle gap on the line.
//
// state     | meaning
// IDLE      | line high, waiting for tx_valid
// START_BIT | driving the start bit (0)
// DATA_BIT  | driving data bit bit_q, LSB first
// STOP_BIT  | driving the stop bit (1)
module uart_tx_byte
  import alu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       txd
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        baud_last;

  assign baud_last = (baud_q == BAUD_LAST);
  assign tx_ready  = (state_q == IDLE) || ((state_q == STOP_BIT) && baud_last);
  assign txd       = txd_q;

  // State and datapath registers; txd resets high so the line idles immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state: advance one bit per baud wrap; load a new byte whenever ready and offered.
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE) ? '0 : (baud_last ? '0 : baud_q + 1'b1);
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;

    case (state_q)
      START_BIT: begin
        if (baud_last) begin
          state_d = DATA_BIT;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA_BIT: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP_BIT: begin
        if (baud_last) begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      end
      default: begin
        txd_d = 1'b1;
      end
    endcase

    if (tx_valid && tx_ready) begin
      state_d = START_BIT;
      baud_d  = '0;
      bit_d   = 3'd0;
      shift_d = tx_byte;
      txd_d   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_result_uart_tx.sv
// Snapshots the ALU result and flags on start and sends them as one 6-byte
// UART frame: header, result MSB first, then {0000, ZF, CF, OF, SF}.
module alu_result_uart_tx
  import alu_io_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
  input  logic                 clk_F,
  input  logic                 rst_n,
  alu_result_uart_tx_if.slave  bus
);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [39:0] shadow_q, shadow_d;

  logic        accept;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        txd;

  // The header goes out on the accept edge itself, so it comes straight from
  // the parameter rather than from the shadow that is being loaded.
  assign accept   = !busy_q && bus.start;
  assign tx_valid = accept || (busy_q && (byte_idx_q != LAST_BYTE_IDX));
  assign tx_byte  = busy_q ? frame_byte(shadow_q, byte_idx_q + 3'd1, HEADER) : HEADER;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk      (clk_F),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_byte  (tx_byte),
    .tx_ready (tx_ready),
    .txd      (txd)
  );

  // Frame sequencing registers.
  always_ff @(posedge clk_F or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      byte_idx_q <= '0;
      shadow_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      byte_idx_q <= byte_idx_d;
      shadow_q   <= shadow_d;
    end
  end

  // Capture on accept; step the byte index at each stop-bit end; finish after the last byte.
  always_comb begin
    busy_d     = busy_q;
    done_d     = 1'b0;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;

    if (accept) begin
      busy_d     = 1'b1;
      byte_idx_d = 3'd0;
      shadow_d   = {bus.data, 4'b0000, bus.flags};
    end else if (busy_q && tx_ready) begin
      if (byte_idx_q == LAST_BYTE_IDX) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        byte_idx_d = byte_idx_q + 3'd1;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.txd  = txd;

endmodule
